// File: rtl/updown_counter_ext_if.sv
// Control/status bundle for updown_counter_ext: the game logic drives the
// controls (master), the counter answers with count, tc and bound flags (slave).
interface updown_counter_ext_if #(
  parameter int WIDTH  = 5,
  parameter int STEP_W = 4
);
  logic              enable;
  logic              up;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [STEP_W-1:0] step;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  count;
  logic              tc;
  logic              at_min;
  logic              at_max;

  modport master (
    output enable, up, load, load_val, step, mode,
    input  count, tc, at_min, at_max
  );

  modport slave (
    input  enable, up, load, load_val, step, mode,
    output count, tc, at_min, at_max
  );
endinterface

// File: rtl/updown_counter_ext.sv
// Up/down range counter [MIN,MAX] with variable step, clamped load, wrap/saturate
// modes and a terminal-count pulse. Define COUNTER_PINGPONG_EN to make mode 10 ping-pong.
module updown_counter_ext #(
  parameter int MIN    = 0,
  parameter int MAX    = 20,
  parameter int WIDTH  = $clog2(MAX + 1),
  parameter int STEP_W = 4
) (
  input logic                 clk,
  input logic                 reset,
  updown_counter_ext_if.slave bus
);
  localparam int EW = WIDTH + STEP_W + 1;
  localparam logic [EW-1:0] C_MIN   = EW'(MIN);
  localparam logic [EW-1:0] C_MAX   = EW'(MAX);
  localparam logic [EW-1:0] C_RANGE = EW'(MAX - MIN + 1);

  typedef enum logic [1:0] {
    MODE_WRAP  = 2'b00,
    MODE_SAT   = 2'b01,
    MODE_PP    = 2'b10,
    MODE_WRAP2 = 2'b11
  } mode_e;

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic [WIDTH-1:0] w_next_count;
  logic             w_next_tc;

  logic [EW-1:0] w_cnt, w_stp, w_sum, w_sub, w_dn_diff, w_lv, w_lv_diff;
  logic [EW-1:0] w_wrap_up, w_wrap_dn;
  logic          w_up_over, w_dn_under;

  assign w_cnt      = EW'(r_count);
  assign w_stp      = EW'(bus.step);
  assign w_sum      = w_cnt + w_stp;
  assign w_sub      = w_cnt - w_stp;
  // Sign bit of the difference flags underflow without comparing against a zero MIN.
  assign w_dn_diff  = w_sub - C_MIN;
  assign w_dn_under = w_dn_diff[EW-1];
  assign w_up_over  = (w_sum > C_MAX);
  assign w_wrap_up  = C_MIN + ((w_sum - C_MAX - EW'(1)) % C_RANGE);
  assign w_wrap_dn  = C_MAX - ((C_MIN - w_sub - EW'(1)) % C_RANGE);
  assign w_lv       = EW'(bus.load_val);
  assign w_lv_diff  = w_lv - C_MIN;

`ifdef COUNTER_PINGPONG_EN
  localparam logic [EW-1:0] C_SPAN  = EW'(MAX - MIN);
  localparam logic [EW-1:0] C_SPAN2 = EW'(2 * (MAX - MIN));

  logic          r_dir;
  logic          w_next_dir;
  logic [EW-1:0] w_pos, w_q, w_r, w_fold, w_pp_val;

  // Fold the travel distance into one bounce period, measured from the bound we leave.
  assign w_pos    = r_dir ? (w_cnt - C_MIN) : (C_MAX - w_cnt);
  assign w_q      = w_pos + w_stp;
  assign w_r      = w_q % C_SPAN2;
  assign w_fold   = (w_r < C_SPAN) ? w_r : (C_SPAN2 - w_r);
  assign w_pp_val = r_dir ? (C_MIN + w_fold) : (C_MAX - w_fold);
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_next_count = r_count;
    w_next_tc    = 1'b0;
`ifdef COUNTER_PINGPONG_EN
    w_next_dir   = r_dir;
`endif
    if (bus.load) begin
      if (w_lv_diff[EW-1])   w_next_count = WIDTH'(C_MIN);
      else if (w_lv > C_MAX) w_next_count = WIDTH'(C_MAX);
      else                   w_next_count = bus.load_val;
    end else if (bus.enable && (bus.step != '0)) begin
      case (mode_e'(bus.mode))
        MODE_SAT: begin
          if (bus.up) begin
            if (w_sum >= C_MAX) begin
              w_next_count = WIDTH'(C_MAX);
              w_next_tc    = (w_cnt != C_MAX);
            end else begin
              w_next_count = WIDTH'(w_sum);
            end
          end else begin
            if (w_dn_under || (w_sub == C_MIN)) begin
              w_next_count = WIDTH'(C_MIN);
              w_next_tc    = (w_cnt != C_MIN);
            end else begin
              w_next_count = WIDTH'(w_sub);
            end
          end
        end
`ifdef COUNTER_PINGPONG_EN
        MODE_PP: begin
          w_next_count = WIDTH'(w_pp_val);
          w_next_tc    = (w_q >= C_SPAN);
          w_next_dir   = (w_r >= C_SPAN) ? ~r_dir : r_dir;
        end
`endif
        default: begin
          if (bus.up) begin
            w_next_count = w_up_over ? WIDTH'(w_wrap_up) : WIDTH'(w_sum);
            w_next_tc    = w_up_over;
          end else begin
            w_next_count = w_dn_under ? WIDTH'(w_wrap_dn) : WIDTH'(w_sub);
            w_next_tc    = w_dn_under;
          end
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= WIDTH'(C_MIN);
      r_tc    <= 1'b0;
`ifdef COUNTER_PINGPONG_EN
      r_dir   <= 1'b1;
`endif
    end else begin
      r_count <= w_next_count;
      r_tc    <= w_next_tc;
`ifdef COUNTER_PINGPONG_EN
      r_dir   <= w_next_dir;
`endif
    end
  end

  assign bus.count  = r_count;
  assign bus.tc     = r_tc;
  assign bus.at_min = (r_count == WIDTH'(C_MIN));
  assign bus.at_max = (r_count == WIDTH'(C_MAX));
endmodule

// File: tb/tb_updown_counter_ext.sv
// Directed bench for updown_counter_ext at default parameters (0..20, STEP_W=4);
// expectations follow COUNTER_PINGPONG_EN when it is defined.
module tb_updown_counter_ext;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  updown_counter_ext_if #(.WIDTH(5), .STEP_W(4)) bus ();

  updown_counter_ext #(.MIN(0), .MAX(20), .WIDTH(5), .STEP_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle, so outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset        = 1'b0;
    bus.enable   = 1'b0;
    bus.up       = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.step     = 4'd0;
    bus.mode     = 2'b00;
  endtask

  task automatic do_load(input logic [4:0] v);
    bus.enable   = 1'b0;
    bus.load     = 1'b1;
    bus.load_val = v;
    tick();
    bus.load     = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (bus.count !== 5'd0 || bus.tc !== 1'b0 || bus.at_min !== 1'b1 || bus.at_max !== 1'b0) begin
      n_errors++;
      $display("FAIL reset: count=%0d tc=%b at_min=%b at_max=%b, want 0 0 1 0",
               bus.count, bus.tc, bus.at_min, bus.at_max);
    end
  endtask

  task automatic test_wrap_up();
    bus.mode = 2'b00; bus.up = 1'b1; bus.step = 4'd1; bus.enable = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      tick();
      n_checks++;
      if (bus.count !== 5'(i % 21) || bus.tc !== (i == 21) || bus.at_max !== (i == 20)) begin
        n_errors++;
        $display("FAIL wrap_up[%0d]: count=%0d tc=%b at_max=%b, want %0d %b %b",
                 i, bus.count, bus.tc, bus.at_max, i % 21, i == 21, i == 20);
      end
    end
    bus.enable = 1'b0;
  endtask

  task automatic test_wrap_down();
    bus.up = 1'b0; bus.step = 4'd3; bus.enable = 1'b1;
    tick();
    n_checks++;
    if (bus.count !== 5'd18 || bus.tc !== 1'b1) begin
      n_errors++;
      $display("FAIL wrap_down_1: count=%0d tc=%b, want 18 1", bus.count, bus.tc);
    end
    tick();
    n_checks++;
    if (bus.count !== 5'd15 || bus.tc !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_down_2: count=%0d tc=%b, want 15 0", bus.count, bus.tc);
    end
    bus.enable = 1'b0;
  endtask

  task automatic test_big_step();
    // Up from 20 by 15: 35 -> 0 + (35-21) mod 21 = 14
    do_load(5'd20);
    bus.mode = 2'b00; bus.up = 1'b1; bus.step = 4'd15; bus.enable = 1'b1;
    tick();
    n_checks++;
    if (bus.count !== 5'd14 || bus.tc !== 1'b1) begin
      n_errors++;
      $display("FAIL big_step_up: count=%0d tc=%b, want 14 1", bus.count, bus.tc);
    end
    // Down from 2 by 15: 20 - (0-(-13)-1) mod 21 = 8
    do_load(5'd2);
    bus.up = 1'b0; bus.enable = 1'b1;
    tick();
    n_checks++;
    if (bus.count !== 5'd8 || bus.tc !== 1'b1) begin
      n_errors++;
      $display("FAIL big_step_down: count=%0d tc=%b, want 8 1", bus.count, bus.tc);
    end
    // Mode 11 also wraps: 18 + 4 = 22 -> 1
    do_load(5'd18);
    bus.mode = 2'b11; bus.up = 1'b1; bus.step = 4'd4; bus.enable = 1'b1;
    tick();
    n_checks++;
    if (bus.count !== 5'd1 || bus.tc !== 1'b1) begin
      n_errors++;
      $display("FAIL mode11_wrap: count=%0d tc=%b, want 1 1", bus.count, bus.tc);
    end
    bus.enable = 1'b0;
  endtask

  task automatic test_saturate();
    do_load(5'd18);
    n_checks++;
    if (bus.count !== 5'd18 || bus.tc !== 1'b0) begin
      n_errors++;
      $display("FAIL load_18: count=%0d tc=%b, want 18 0", bus.count, bus.tc);
    end
    bus.mode = 2'b01; bus.up = 1'b1; bus.step = 4'd5; bus.enable = 1'b1;
    tick();
    n_checks++;
    if (bus.count !== 5'd20 || bus.tc !== 1'b1) begin
      n_errors++;
      $display("FAIL sat_up_clamp: count=%0d tc=%b, want 20 1", bus.count, bus.tc);
    end
    tick();
    n_checks++;
    if (bus.count !== 5'd20 || bus.tc !== 1'b0 || bus.at_max !== 1'b1) begin
      n_errors++;
      $display("FAIL sat_up_hold: count=%0d tc=%b at_max=%b, want 20 0 1",
               bus.count, bus.tc, bus.at_max);
    end
    // Exact landing on MAX also pulses tc
    do_load(5'd15);
    bus.enable = 1'b1;
    tick();
    n_checks++;
    if (bus.count !== 5'd20 || bus.tc !== 1'b1) begin
      n_errors++;
      $display("FAIL sat_up_exact: count=%0d tc=%b, want 20 1", bus.count, bus.tc);
    end
    do_load(5'd2);
    bus.up = 1'b0; bus.enable = 1'b1;
    tick();
    n_checks++;
    if (bus.count !== 5'd0 || bus.tc !== 1'b1 || bus.at_min !== 1'b1) begin
      n_errors++;
      $display("FAIL sat_down_clamp: count=%0d tc=%b at_min=%b, want 0 1 1",
               bus.count, bus.tc, bus.at_min);
    end
    tick();
    n_checks++;
    if (bus.count !== 5'd0 || bus.tc !== 1'b0) begin
      n_errors++;
      $display("FAIL sat_down_hold: count=%0d tc=%b, want 0 0", bus.count, bus.tc);
    end
    bus.enable = 1'b0;
  endtask

  task automatic test_priority();
    bus.mode = 2'b00; bus.up = 1'b1; bus.step = 4'd1;
    bus.load = 1'b1; bus.load_val = 5'd25; bus.enable = 1'b1; reset = 1'b1;
    tick();
    n_checks++;
    if (bus.count !== 5'd0 || bus.tc !== 1'b0) begin
      n_errors++;
      $display("FAIL prio_reset: count=%0d tc=%b, want 0 0", bus.count, bus.tc);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (bus.count !== 5'd20 || bus.tc !== 1'b0 || bus.at_max !== 1'b1) begin
      n_errors++;
      $display("FAIL prio_load_clamp: count=%0d tc=%b at_max=%b, want 20 0 1",
               bus.count, bus.tc, bus.at_max);
    end
    bus.load = 1'b0; bus.enable = 1'b0;
  endtask

  task automatic test_hold_and_reset();
    do_load(5'd7);
    bus.mode = 2'b00; bus.up = 1'b1; bus.step = 4'd0; bus.enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (bus.count !== 5'd7 || bus.tc !== 1'b0) begin
        n_errors++;
        $display("FAIL step0_hold[%0d]: count=%0d tc=%b, want 7 0", i, bus.count, bus.tc);
      end
    end
    bus.step = 4'd2;
    tick();
    n_checks++;
    if (bus.count !== 5'd9) begin
      n_errors++;
      $display("FAIL step2: count=%0d, want 9", bus.count);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (bus.count !== 5'd0 || bus.tc !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset: count=%0d tc=%b, want 0 0", bus.count, bus.tc);
    end
    bus.enable = 1'b0;
  endtask

  task automatic test_pingpong();
    logic [4:0] exp_c [8];
    logic       exp_t [8];
`ifdef COUNTER_PINGPONG_EN
    exp_c = '{5'd18, 5'd15, 5'd12, 5'd9, 5'd6, 5'd3, 5'd0, 5'd3};
    exp_t = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    exp_c = '{5'd1, 5'd4, 5'd7, 5'd10, 5'd13, 5'd16, 5'd19, 5'd1};
    exp_t = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    do_load(5'd19);
    bus.mode = 2'b10; bus.up = 1'b1; bus.step = 4'd3; bus.enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (bus.count !== exp_c[i] || bus.tc !== exp_t[i]) begin
        n_errors++;
        $display("FAIL mode10[%0d]: count=%0d tc=%b, want %0d %b",
                 i, bus.count, bus.tc, exp_c[i], exp_t[i]);
      end
    end
    bus.enable = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_big_step();
    test_saturate();
    test_priority();
    test_hold_and_reset();
    test_pingpong();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
